// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: latches opcode/funct at fetch, then walks
// each instruction through DECODE/EXECUTE/MEMORY/WRITEBACK, stalling on the
// instruction- and data-memory ready handshakes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | wait for imem_ready, latch IR, PC <= PC+4
// DECODE    | resolve jumps/syscall/NOP, otherwise go to EXECUTE
// EXECUTE   | ALU operation; branches resolve here
// MEMORY    | lw/sw request held until dmem_ready
// WRITEBACK | one-cycle register-file write
// HALT      | syscall executed; left only through reset
module multicycle_controller #(
    parameter logic [2:0] ALU_ADD = 3'd0,
    parameter logic [2:0] ALU_SUB = 3'd1,
    parameter logic [2:0] ALU_SLT = 3'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        alu_zero,
    output logic        ir_load,
    output logic        pc_wr_en,
    output logic [1:0]  pc_src,
    output logic [1:0]  reg_dst,
    output logic        reg_wr_en,
    output logic        ext_sel,
    output logic        alu_src_b,
    output logic [2:0]  alu_command,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [1:0]  mem_out_src,
    output logic        halted,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] FN_JR    = 6'd8;
    localparam logic [5:0] FN_SYS   = 6'd12;
    localparam logic [5:0] FN_ADD   = 6'd32;

    state_t     cur;
    logic [5:0] opcode;
    logic [5:0] funct;

    // Only opcode and funct drive control; the remaining fields feed the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instruction[25:6];

    logic is_r, is_syscall, is_jr, is_add, is_j, is_jal;
    logic is_addi, is_addiu, is_slti, is_beq, is_bne, is_lw, is_sw;
    logic is_branch, is_imm, to_exec;

    assign is_r       = (opcode == OP_RTYPE);
    assign is_syscall = is_r && (funct == FN_SYS);
    assign is_jr      = is_r && (funct == FN_JR);
    assign is_add     = is_r && (funct == FN_ADD);
    assign is_j       = (opcode == OP_J);
    assign is_jal     = (opcode == OP_JAL);
    assign is_addi    = (opcode == OP_ADDI);
    assign is_addiu   = (opcode == OP_ADDIU);
    assign is_slti    = (opcode == OP_SLTI);
    assign is_beq     = (opcode == OP_BEQ);
    assign is_bne     = (opcode == OP_BNE);
    assign is_lw      = (opcode == OP_LW);
    assign is_sw      = (opcode == OP_SW);
    assign is_branch  = is_beq || is_bne;
    assign is_imm     = is_addi || is_addiu || is_slti;
    assign to_exec    = is_add || is_imm || is_branch || is_lw || is_sw;

    assign state = cur;

    // State sequencing and opcode/funct capture at fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= S_FETCH;
            opcode <= 6'd0;
            funct  <= 6'd0;
        end else begin
            case (cur)
                S_FETCH: if (imem_ready) begin
                    opcode <= instruction[31:26];
                    funct  <= instruction[5:0];
                    cur    <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_syscall)   cur <= S_HALT;
                    else if (to_exec) cur <= S_EXECUTE;
                    else              cur <= S_FETCH;
                end
                S_EXECUTE: begin
                    if (is_branch)          cur <= S_FETCH;
                    else if (is_lw || is_sw) cur <= S_MEMORY;
                    else                    cur <= S_WRITEBACK;
                end
                S_MEMORY: if (dmem_ready) cur <= is_lw ? S_WRITEBACK : S_FETCH;
                S_WRITEBACK: cur <= S_FETCH;
                S_HALT:      cur <= S_HALT;
                default:     cur <= S_FETCH;
            endcase
        end
    end

    // Control outputs decoded from the current state and latched fields.
    always_comb begin
        ir_load     = 1'b0;
        pc_wr_en    = 1'b0;
        pc_src      = 2'd0;
        reg_dst     = 2'd0;
        reg_wr_en   = 1'b0;
        ext_sel     = 1'b0;
        alu_src_b   = 1'b0;
        alu_command = ALU_ADD;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_out_src = 2'd0;
        halted      = 1'b0;
        case (cur)
            S_FETCH: if (imem_ready) begin
                ir_load  = 1'b1;
                pc_wr_en = 1'b1;
            end
            S_DECODE: begin
                if (is_j || is_jal) begin
                    pc_wr_en = 1'b1;
                    pc_src   = 2'd2;
                end
                if (is_jal) begin
                    reg_wr_en   = 1'b1;
                    reg_dst     = 2'd2;
                    mem_out_src = 2'd2;
                end
                if (is_jr) begin
                    pc_wr_en = 1'b1;
                    pc_src   = 2'd1;
                end
            end
            S_EXECUTE, S_MEMORY: begin
                alu_src_b = is_imm || is_lw || is_sw;
                ext_sel   = is_addiu;
                if (is_slti)   alu_command = ALU_SLT;
                if (is_branch) begin
                    alu_command = ALU_SUB;
                    pc_src      = 2'd3;
                    pc_wr_en    = is_beq ? alu_zero : !alu_zero;
                end
                if (cur == S_MEMORY) begin
                    mem_rd_en = is_lw;
                    mem_wr_en = is_sw;
                end
            end
            S_WRITEBACK: begin
                reg_wr_en = 1'b1;
                if (is_lw) begin
                    reg_dst     = 2'd1;
                    mem_out_src = 2'd1;
                end else if (is_imm) begin
                    reg_dst   = 2'd1;
                    alu_src_b = 1'b1;
                    ext_sel   = is_addiu;
                    if (is_slti) alu_command = ALU_SLT;
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a per-instruction expected cycle trace is
// built from the instruction class, wait counts and alu_zero, then replayed
// against the DUT one cycle at a time.
module tb_multicycle_controller;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_load;
        logic       pc_wr_en;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic       reg_wr_en;
        logic       ext_sel;
        logic       alu_src_b;
        logic [2:0] alu_command;
        logic       mem_rd_en;
        logic       mem_wr_en;
        logic [1:0] mem_out_src;
        logic       halted;
    } outs_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        imem;
        logic        dmem;
        logic        zero;
        outs_t       exp;
    } cyc_t;

    logic        clk, rst_n;
    logic [31:0] instruction;
    logic        imem_ready, dmem_ready, alu_zero;
    logic        ir_load, pc_wr_en, reg_wr_en, ext_sel, alu_src_b;
    logic        mem_rd_en, mem_wr_en, halted;
    logic [1:0]  pc_src, reg_dst, mem_out_src;
    logic [2:0]  alu_command, state;

    int total = 0;
    int fails = 0;
    cyc_t q[$];

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .alu_zero(alu_zero),
        .ir_load(ir_load), .pc_wr_en(pc_wr_en), .pc_src(pc_src),
        .reg_dst(reg_dst), .reg_wr_en(reg_wr_en), .ext_sel(ext_sel),
        .alu_src_b(alu_src_b), .alu_command(alu_command),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_out_src(mem_out_src), .halted(halted), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    outs_t got;
    assign got = '{st: state, ir_load: ir_load, pc_wr_en: pc_wr_en, pc_src: pc_src,
                   reg_dst: reg_dst, reg_wr_en: reg_wr_en, ext_sel: ext_sel,
                   alu_src_b: alu_src_b, alu_command: alu_command,
                   mem_rd_en: mem_rd_en, mem_wr_en: mem_wr_en,
                   mem_out_src: mem_out_src, halted: halted};

    function automatic logic rb();
        return ($urandom & 32'd1) != 32'd0;
    endfunction

    task automatic check(input string tag, input outs_t exp);
        total++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic im, input logic dm,
                        input logic z, input outs_t e);
        cyc_t c;
        c.instr = w; c.imem = im; c.dmem = dm; c.zero = z; c.exp = e;
        q.push_back(c);
    endtask

    // Expected trace of one instruction from its class.
    task automatic gen(input logic [31:0] w, input int iw, input int dw, input logic z);
        logic [5:0] op, fn;
        logic k_sys, k_jr, k_add, k_j, k_jal, k_imm, k_beq, k_bne, k_lw, k_sw;
        outs_t e, a;
        op = w[31:26]; fn = w[5:0];
        k_sys = (op == 0) && (fn == 12);
        k_jr  = (op == 0) && (fn == 8);
        k_add = (op == 0) && (fn == 32);
        k_j   = (op == 2);
        k_jal = (op == 3);
        k_imm = (op == 8) || (op == 9) || (op == 10);
        k_beq = (op == 4);
        k_bne = (op == 5);
        k_lw  = (op == 35);
        k_sw  = (op == 43);
        for (int i = 0; i < iw; i++) begin
            e = '0;
            push($urandom, 1'b0, rb(), rb(), e);
        end
        e = '0; e.ir_load = 1; e.pc_wr_en = 1;
        push(w, 1'b1, rb(), rb(), e);
        e = '0; e.st = 3'd1;
        if (k_j || k_jal) begin e.pc_wr_en = 1; e.pc_src = 2; end
        if (k_jal) begin e.reg_wr_en = 1; e.reg_dst = 2; e.mem_out_src = 2; end
        if (k_jr) begin e.pc_wr_en = 1; e.pc_src = 1; end
        push($urandom, rb(), rb(), rb(), e);
        if (!(k_add || k_imm || k_beq || k_bne || k_lw || k_sw)) return;
        a = '0;
        a.alu_src_b = k_imm || k_lw || k_sw;
        a.ext_sel = (op == 9);
        a.alu_command = (op == 10) ? 3'd3 : (k_beq || k_bne) ? 3'd1 : 3'd0;
        e = a; e.st = 3'd2;
        if (k_beq || k_bne) begin
            e.pc_src = 3;
            e.pc_wr_en = k_beq ? z : !z;
        end
        push($urandom, rb(), rb(), z, e);
        if (k_beq || k_bne) return;
        if (k_lw || k_sw) begin
            e = a; e.st = 3'd3; e.mem_rd_en = k_lw; e.mem_wr_en = k_sw;
            for (int i = 0; i < dw; i++) push($urandom, rb(), 1'b0, rb(), e);
            push($urandom, rb(), 1'b1, rb(), e);
            if (k_sw) return;
        end
        e = '0; e.st = 3'd4; e.reg_wr_en = 1;
        if (k_lw) begin e.reg_dst = 1; e.mem_out_src = 1; end
        else if (k_imm) begin e = a; e.st = 3'd4; e.reg_wr_en = 1; e.reg_dst = 1; end
        push($urandom, rb(), rb(), rb(), e);
    endtask

    task automatic run_n(input string tag, input int n);
        cyc_t c;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            c = q.pop_front();
            @(negedge clk);
            instruction = c.instr; imem_ready = c.imem;
            dmem_ready = c.dmem; alu_zero = c.zero;
            #1 check(tag, c.exp);
        end
    endtask

    task automatic do_reset(input string tag);
        outs_t z;
        z = '0;
        @(negedge clk);
        imem_ready = 0; dmem_ready = 0;
        #2 rst_n = 0;
        #1 check(tag, z);
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    logic [31:0] pool [12];
    outs_t hexp;

    initial begin
        pool = '{32'h00000020, 32'h8C220004, 32'h10220003, 32'h14220003,
                 32'h0C000010, 32'h03E00008, 32'h08000000, 32'h20010005,
                 32'h24010005, 32'h28010005, 32'hAC220004, 32'h00000021};
        rst_n = 1; instruction = 0; imem_ready = 0; dmem_ready = 0; alu_zero = 0;
        #2 rst_n = 0;
        #1 check("reset", '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1 check("idle_after_reset", '0);

        gen(32'h00000020, 0, 0, 0); run_n("add", 99);
        gen(32'h8C220004, 1, 3, 0); run_n("lw_wait", 99);
        gen(32'h10220003, 0, 0, 1); run_n("beq_taken", 99);
        gen(32'h10220003, 0, 0, 0); run_n("beq_not", 99);
        gen(32'h14220003, 0, 0, 1); run_n("bne_zero", 99);
        gen(32'h14220003, 0, 0, 0); run_n("bne_taken", 99);
        gen(32'h0C000010, 0, 0, 0); run_n("jal", 99);
        gen(32'h03E00008, 2, 0, 0); run_n("jr", 99);
        gen(32'h08000000, 0, 0, 0); run_n("j", 99);
        gen(32'h20010005, 0, 0, 0); run_n("addi", 99);
        gen(32'h24010005, 0, 0, 0); run_n("addiu", 99);
        gen(32'h28010005, 0, 0, 0); run_n("slti", 99);
        gen(32'hAC220004, 0, 0, 0); run_n("sw", 99);
        gen(32'h00000021, 0, 0, 0); run_n("nop_rtype", 99);

        for (int n = 0; n < 40; n++) begin
            gen(pool[$urandom_range(11, 0)], int'($urandom_range(2, 0)),
                int'($urandom_range(3, 0)), rb());
            run_n("random", 99);
        end

        gen(32'hAC220004, 0, 5, 0);
        run_n("sw_abort", 5);
        do_reset("reset_in_memory");
        gen(32'hFC000000, 0, 0, 0); run_n("nop_3f", 99);
        gen(32'h00000020, 0, 0, 0); run_n("add_after_nop", 99);

        gen(32'h0000000C, 1, 0, 0); run_n("syscall", 99);
        hexp = '0; hexp.st = 3'd5; hexp.halted = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            instruction = $urandom; imem_ready = 1; dmem_ready = rb(); alu_zero = rb();
            #1 check("halt_hold", hexp);
        end
        do_reset("reset_from_halt");
        gen(32'h8C220004, 0, 0, 0); run_n("lw_after_halt", 99);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
